// File: rtl/snes_bus_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : snes_bus_monitor
// Description : Settle/latch synchroniser for the raw asynchronous SNES
//               cartridge-edge address/data bus, running in the 40 MHz clk
//               domain. It synchronises the address bus and detects address
//               switches. Once the bus has settled, it latches address and
//               data, raises per-slot address match strobes and queues every
//               capture into a small valid/ready FIFO with a sticky
//               overflow flag.
// Revision    : 1.0 - initial parametrised release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1            40 MHz board clock
//   rst_n        in   1            asynchronous active-low reset
//   PA           in   AW           raw SNES address bus (asynchronous)
//   D            in   DW           raw SNES data bus (asynchronous)
//   match_addr   in   NMATCH*AW    match addresses, slot i at [i*AW +: AW]
//   match_en     in   NMATCH       per-slot match enable
//   PA_sync      out  AW           last synchroniser stage of the address
//   PA_cap       out  AW           address captured at the latch point
//   D_cap        out  DW           data captured at the latch point
//   event_latch  out  1            capture valid, bus still in quiet window
//   latch_strobe out  1            one-cycle pulse, the cycle after capture
//   hit          out  NMATCH       per-slot match pulse, aligned to strobe
//   fifo_valid   out  1            capture FIFO non-empty
//   fifo_addr    out  AW           head entry address (0 when empty)
//   fifo_data    out  DW           head entry data (0 when empty)
//   fifo_ready   in   1            pop head when fifo_valid && fifo_ready
//   fifo_ovf     out  1            sticky: a capture was dropped on full FIFO
//   ovf_clr      in   1            clears fifo_ovf (a new overflow wins)
// ============================================================================
module snes_bus_monitor #(
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 3,
    parameter int HOLDOFF     = 5,
    parameter int LATCH_DLY   = 5,
    parameter int QUIET_CNT   = 18,
    parameter int CW          = 5,
    parameter int NMATCH      = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [AW-1:0]        PA,
    input  logic [DW-1:0]        D,
    input  logic [NMATCH*AW-1:0] match_addr,
    input  logic [NMATCH-1:0]    match_en,
    output logic [AW-1:0]        PA_sync,
    output logic [AW-1:0]        PA_cap,
    output logic [DW-1:0]        D_cap,
    output logic                 event_latch,
    output logic                 latch_strobe,
    output logic [NMATCH-1:0]    hit,
    output logic                 fifo_valid,
    output logic [AW-1:0]        fifo_addr,
    output logic [DW-1:0]        fifo_data,
    input  logic                 fifo_ready,
    output logic                 fifo_ovf,
    input  logic                 ovf_clr
);

    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_HOLDOFF = CW'(HOLDOFF);
    localparam logic [CW-1:0] CNT_LATCH   = CW'(LATCH_DLY);
    localparam logic [CW-1:0] CNT_QUIET   = CW'(QUIET_CNT);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (!((HOLDOFF <= LATCH_DLY) && (LATCH_DLY < QUIET_CNT) &&
          (QUIET_CNT < (1 << CW)) && (SYNC_STAGES >= 2) &&
          (FIFO_DEPTH >= 2) && ((1 << PW) == FIFO_DEPTH))) begin : g_param_check
        $error("snes_bus_monitor: illegal parameter combination");
    end

    // ------------------------------------------------------------------
    // Address synchroniser / compare pipeline and data double-flop
    // ------------------------------------------------------------------
    logic [AW-1:0] sync_q [SYNC_STAGES];
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            d1 <= '0;
            d2 <= '0;
        end else begin
            sync_q[0] <= PA;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            d1 <= D;
            d2 <= d1;
        end
    end

    assign PA_sync = sync_q[SYNC_STAGES-1];

    // The bus counts as settled only when every pipeline stage agrees; the
    // raw PA pins never take part in the comparison, so metastable samples
    // in stage 0 can only ever look like a change, never like stability.
    logic stable;
    logic change;

    always_comb begin
        stable = 1'b1;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            if (sync_q[k] != sync_q[0]) begin
                stable = 1'b0;
            end
        end
    end

    assign change = ~stable;

    // ------------------------------------------------------------------
    // Per-slot address match, evaluated on the value being captured so the
    // registered hit lines up with the new PA_cap.
    // ------------------------------------------------------------------
    logic [NMATCH-1:0] slot_hit;

    for (genvar i = 0; i < NMATCH; i++) begin : g_match
        assign slot_hit[i] = match_en[i] && (PA_sync == match_addr[i*AW +: AW]);
    end

    // ------------------------------------------------------------------
    // Settle FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IN_SYNC     = 2'b00,
        OUT_OF_SYNC = 2'b01
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          accept_change;
    logic          capture;

    // A change is only honoured once the bus has been settled past the
    // holdoff window; earlier changes are treated as glitches and the count
    // simply keeps running.
    assign accept_change = change && (cnt > CNT_HOLDOFF);
    assign capture       = (state == IN_SYNC) && !accept_change && (cnt == CNT_LATCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IN_SYNC;
            cnt          <= '0;
            event_latch  <= 1'b0;
            latch_strobe <= 1'b0;
            hit          <= '0;
            PA_cap       <= '0;
            D_cap        <= '0;
        end else begin
            latch_strobe <= 1'b0;
            hit          <= '0;
            case (state)
                IN_SYNC: begin
                    if (accept_change) begin
                        state       <= OUT_OF_SYNC;
                        cnt         <= '0;
                        event_latch <= 1'b0;
                    end else begin
                        // Saturation at QUIET_CNT guarantees a single
                        // capture per settle: LATCH_DLY is only revisited
                        // after the counter is cleared by a new change.
                        if (cnt != CNT_QUIET) begin
                            cnt <= cnt + CW'(1);
                        end
                        if (capture) begin
                            PA_cap       <= PA_sync;
                            D_cap        <= d2;
                            event_latch  <= 1'b1;
                            latch_strobe <= 1'b1;
                            hit          <= slot_hit;
                        end else if (cnt == CNT_QUIET) begin
                            event_latch <= 1'b0;
                        end
                    end
                end
                OUT_OF_SYNC: begin
                    cnt         <= '0;
                    event_latch <= 1'b0;
                    if (stable) begin
                        state <= IN_SYNC;
                    end
                end
                default: begin
                    state       <= IN_SYNC;
                    cnt         <= '0;
                    event_latch <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Capture FIFO. Pointers carry one extra wrap bit so full and empty are
    // distinguishable without a separate occupancy counter.
    // ------------------------------------------------------------------
    logic [AW-1:0] mem_addr [FIFO_DEPTH];
    logic [DW-1:0] mem_data [FIFO_DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop   = !empty && fifo_ready;
    // On a full FIFO a simultaneous pop frees the head slot this very edge,
    // so the push writes into the slot being vacated.
    assign push  = capture && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_ovf <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
            end
            if (capture && full && !pop) begin
                fifo_ovf <= 1'b1;
            end else if (ovf_clr) begin
                fifo_ovf <= 1'b0;
            end
        end
    end

    // Storage carries no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr[PW-1:0]] <= PA_sync;
            mem_data[wr_ptr[PW-1:0]] <= d2;
        end
    end

    assign fifo_valid = !empty;
    assign fifo_addr  = fifo_valid ? mem_addr[rd_ptr[PW-1:0]] : '0;
    assign fifo_data  = fifo_valid ? mem_data[rd_ptr[PW-1:0]] : '0;

endmodule
`default_nettype wire
